mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between instruction fetch (IF) and the MEM stage (loads, stores, LL/SC).
- Sequences each access with a req/ready handshake.
- Performs byte-lane steering and byte-load extension.
- Resolves store-conditional results.
- Generates per-stage stall signals for the pipeline.

Parameters:
- STARVE_LIMIT, 4: consecutive arbitration losses by IF before IF is forced to win.
- TIMEOUT, 255: cycles a memory transaction may wait for mem_ready before it is aborted.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; level, held until if_ack.
- if_addr  in  32  fetch byte address; bits [1:0] ignored.
- if_rdata  out  32  fetched instruction; valid while if_ack.
- if_ack  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request (mem_read | mem_we); held until dm_ack.
- dm_we  in  1  store.
- dm_byte  in  1  byte access.
- dm_signextend  in  1  sign-extend byte loads.
- dm_sc  in  1  store-conditional.
- dm_sc_mask  in  1  store-conditional must not store.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data (byte in [7:0]).
- dm_rdata  out  32  load result or SC result; valid while dm_ack.
- dm_ack  out  1  one-cycle data completion pulse.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_be  out  4  byte enables; bit 3 = bits [31:24].
- mem_addr  out  32  word address {addr[31:2], 2'b00}.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data; valid when mem_ready.
- mem_ready  in  1  completes the current transaction.
- stall_if  out  1  if_req & ~if_ack.
- stall_mem  out  1  dm_req & ~dm_ack.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, rst=0): state IDLE, starve_cnt=0, tmo_cnt=0, mem_err=0.
  - Registered outputs at reset: mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0.
  - Reset mid-transaction drops mem_req in the same instant; no ack is issued for the aborted transaction.
- States: IDLE, FETCH, DATA, SC_FAIL.
- IDLE arbitration, per cycle, in this order:
  - dm_req & dm_sc & dm_sc_mask -> SC_FAIL. No memory access.
  - dm_req only -> DATA.
  - if_req only -> FETCH.
  - Both requests: DATA wins unless starve_cnt == STARVE_LIMIT, in which case FETCH wins.
  - starve_cnt increments (saturating) each time IF loses; it clears on an IF grant.
- On entering FETCH or DATA, the following are registered: mem_req=1, mem_addr, mem_we, mem_be, mem_wdata.
  - These hold stable until the cycle mem_ready=1 is sampled, then return to IDLE with mem_req=0.
  - Minimum latency, request to ack, is 2 cycles: grant edge, then ready edge. The ack pulse is registered.
  - At least one IDLE cycle separates transactions.
- Ack pulse:
  - if_ack or dm_ack is high for exactly one cycle, the cycle after mem_ready is sampled.
  - rdata registers hold the returned value until the next ack.
- Byte lanes (big-endian): addr[1:0]=0 -> [31:24] … addr[1:0]=3 -> [7:0].
  - Word access: mem_be=4'b1111.
  - Byte store: mem_be is one-hot and mem_wdata = {4{dm_wdata[7:0]}}.
  - Byte load: the selected byte is zero- or sign-extended per dm_signextend.
- SC:
  - Unmasked SC performs a word store; dm_rdata=32'd1.
  - SC_FAIL acks next cycle with dm_rdata=32'd0 and mem_we never asserted.
- Timeout:
  - tmo_cnt counts cycles in FETCH/DATA with mem_ready=0.
  - When tmo_cnt reaches TIMEOUT: drop mem_req, set mem_err (sticky until reset), ack the requester with rdata=32'hDEAD_BEEF, return to IDLE.
- A requester dropping req before ack is illegal; the transaction completes anyway.
- mem_ready in IDLE is ignored.

Decomposition:
- Shared package mem_arb_defines.v: state encodings, SC_SUCCESS=1, SC_FAIL_VAL=0, ERR_DATA=32'hDEAD_BEEF.
- One sub-module, byte_lane_steer: combinational.
  - Inputs: addr[1:0], byte, signextend, wdata, mem_rdata.
  - Outputs: be, steered wdata, extended rdata.

Test Plan:
- if_req, addr 0x40; memory readies 3 cycles after mem_req with 0x2408_0005 -> mem_addr=0x40, mem_be=F, if_ack one cycle with if_rdata=0x2408_0005; stall_if high until then.
- Simultaneous if_req/dm_req held for 6 transactions, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D; starve_cnt clears after F.
- dm_req, byte load, addr 0x103, signextend=1, mem_rdata=0x1122_33F0 -> dm_rdata=0xFFFF_FFF0; with signextend=0 -> 0x0000_00F0.
- Byte store addr 0x101, dm_wdata=0xAB -> mem_be=4'b0100, mem_wdata=0xABAB_ABAB, mem_we=1.
- SC with dm_sc_mask=1 -> no mem_req, dm_ack next cycle, dm_rdata=0. SC unmasked -> word store, dm_rdata=1.
- mem_ready never asserts, TIMEOUT=8 -> mem_req drops after 8 cycles, mem_err=1, ack with 0xDEAD_BEEF. Then assert rst low mid-fetch -> mem_req=0 immediately, no ack, mem_err cleared.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM states, result codes
// and small address/lane helpers.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DATA,
      ST_SC_FAIL
   } arb_state_e;

   localparam logic [31:0] SC_SUCCESS  = 32'd1;
   localparam logic [31:0] SC_FAIL_VAL = 32'd0;
   localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;

   // Word-align a byte address for the memory bus.
   function automatic logic [31:0] word_addr(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

   // Big-endian lane pick: lane 0 is bits [31:24], lane 3 is bits [7:0].
   function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
      logic [7:0] b;
      unique case (lane)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_byte_lane_steer.sv
// Combinational byte-lane steering: byte enables, store data replication
// and zero/sign extension of byte loads.
module byte_lane_steer
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0]  lane,
   input  logic        byte_acc,
   input  logic        sign_ext,
   input  logic [31:0] wdata,
   input  logic [31:0] mem_rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_out,
   output logic [31:0] rdata_out
);

   logic [7:0] sel_byte;

   // Word accesses pass through; byte accesses use one lane.
   always_comb begin
      sel_byte  = lane_byte(mem_rdata, lane);
      be        = 4'b1111;
      wdata_out = wdata;
      rdata_out = mem_rdata;
      if (byte_acc) begin
         be        = 4'b1000 >> lane;
         wdata_out = {4{wdata[7:0]}};
         rdata_out = {{24{sign_ext & sel_byte[7]}}, sel_byte};
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction
// fetch and the MEM stage, with starvation guard, SC resolution and timeout.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT      = 255
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic        dm_byte,
   input  logic        dm_signextend,
   input  logic        dm_sc,
   input  logic        dm_sc_mask,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        stall_if,
   output logic        stall_mem,
   output logic        mem_err
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   arb_state_e      state_q, state_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            err_q, err_d;
   logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [3:0]      mem_be_q, mem_be_d;
   logic [31:0]     mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic            if_ack_q, if_ack_d, dm_ack_q, dm_ack_d;
   logic [31:0]     if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
   logic [1:0]      lane_q, lane_d;
   logic            byte_q, byte_d, sext_q, sext_d, sc_q, sc_d;

   logic [1:0]      st_lane;
   logic            st_byte, st_sext;
   logic [3:0]      st_be;
   logic [31:0]     st_wdata, st_rdata;

   // In IDLE the steering follows the live request (to register be/wdata);
   // during DATA it follows the attributes latched at grant (to extend rdata).
   always_comb begin
      if (state_q == ST_IDLE) begin
         st_lane = dm_addr[1:0];
         st_byte = dm_byte & ~dm_sc;
         st_sext = dm_signextend;
      end else begin
         st_lane = lane_q;
         st_byte = byte_q;
         st_sext = sext_q;
      end
   end

   byte_lane_steer u_steer (
      .lane      (st_lane),
      .byte_acc  (st_byte),
      .sign_ext  (st_sext),
      .wdata     (dm_wdata),
      .mem_rdata (mem_rdata),
      .be        (st_be),
      .wdata_out (st_wdata),
      .rdata_out (st_rdata)
   );

   // Next-state, arbitration, timeout and registered-output computation.
   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      tmo_d       = tmo_q;
      err_d       = err_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_ack_d    = 1'b0;
      dm_ack_d    = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      lane_d      = lane_q;
      byte_d      = byte_q;
      sext_d      = sext_q;
      sc_d        = sc_q;
      unique case (state_q)
         ST_IDLE: begin
            mem_req_d = 1'b0;
            if (dm_req && dm_sc && dm_sc_mask) begin
               state_d = ST_SC_FAIL;
            end else if (if_req && (!dm_req || starve_q == SW'(STARVE_LIMIT))) begin
               state_d    = ST_FETCH;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_be_d   = '1;
               mem_addr_d = word_addr(if_addr);
            end else if (dm_req) begin
               state_d     = ST_DATA;
               mem_req_d   = 1'b1;
               mem_we_d    = dm_we | dm_sc;
               mem_be_d    = st_be;
               mem_addr_d  = word_addr(dm_addr);
               mem_wdata_d = st_wdata;
               lane_d      = dm_addr[1:0];
               byte_d      = st_byte;
               sext_d      = dm_signextend;
               sc_d        = dm_sc;
            end
            if (state_d == ST_FETCH) begin
               starve_d = '0;
            end else if (if_req && starve_q != SW'(STARVE_LIMIT)) begin
               starve_d = starve_q + SW'(1);
            end
         end
         ST_FETCH, ST_DATA: begin
            if (mem_ready || tmo_q == TW'(TIMEOUT - 1)) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               tmo_d     = '0;
               if (state_q == ST_FETCH) begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = mem_ready ? mem_rdata : ERR_DATA;
               end else begin
                  dm_ack_d   = 1'b1;
                  dm_rdata_d = !mem_ready ? ERR_DATA : (sc_q ? SC_SUCCESS : st_rdata);
               end
               if (!mem_ready) begin
                  err_d = 1'b1;
               end
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_SC_FAIL: begin
            state_d    = ST_IDLE;
            dm_ack_d   = 1'b1;
            dm_rdata_d = SC_FAIL_VAL;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered outputs; reset aborts any transaction silently.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         starve_q    <= '0;
         tmo_q       <= '0;
         err_q       <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         lane_q      <= '0;
         byte_q      <= 1'b0;
         sext_q      <= 1'b0;
         sc_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         tmo_q       <= tmo_d;
         err_q       <= err_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ack_q    <= if_ack_d;
         dm_ack_q    <= dm_ack_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         lane_q      <= lane_d;
         byte_q      <= byte_d;
         sext_q      <= sext_d;
         sc_q        <= sc_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_ack    = if_ack_q;
   assign dm_ack    = dm_ack_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign mem_err   = err_q;
   assign stall_if  = if_req & ~if_ack_q;
   assign stall_mem = dm_req & ~dm_ack_q;

endmodule
